// File: rtl/quad_pkg.sv
// Shared types and helpers for the quadrature encoder emulator.
// Phase is the {A,B} pair; forward order is 00 -> 10 -> 11 -> 01.
package quad_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_FWD = 1'b1;
  localparam logic DIR_REV = 1'b0;

  // Adjacent entries differ in one bit, so every step is a single-edge change.
  function automatic logic [1:0] phase_fwd(input logic [1:0] ph);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = PH_10;
      PH_10:   nxt = PH_11;
      PH_11:   nxt = PH_01;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

  function automatic logic [1:0] phase_rev(input logic [1:0] ph);
    logic [1:0] nxt;
    nxt = PH_00;
    case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_step_timer.sv
// Loadable down-counter pacing quadrature edges; ticks when enabled at zero
// and reloads itself with period-1 on that tick.
module quad_step_timer #(
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic [DIV_WIDTH-1:0] period_i,
  input  logic                 en_i,
  output logic                 tick_o
);

  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0] reload_q, reload_d;
  logic [DIV_WIDTH-1:0] period_m1;

  // A period of zero behaves as one, giving a reload value of zero.
  assign period_m1 = (period_i == '0) ? '0 : period_i - DIV_WIDTH'(1);

  assign tick_o = en_i && (cnt_q == '0);

  always_comb begin
    cnt_d    = cnt_q;
    reload_d = reload_q;
    if (load_i) begin
      cnt_d    = period_m1;
      reload_d = period_m1;
    end else if (tick_o) begin
      cnt_d = reload_q;
    end else if (en_i) begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q    <= '0;
      reload_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      reload_q <= reload_d;
    end
  end

endmodule

// File: rtl/quad_encoder_gen.sv
// Quadrature encoder emulator: accepts move commands and emits a Gray-coded
// A/B pair at the commanded rate while tracking the resulting position.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high
// RUN   | emitting edges, one per timer tick, until remaining hits zero or abort
module quad_encoder_gen
  import quad_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_dir,
  input  logic [WIDTH-1:0]     cmd_steps,
  input  logic [DIV_WIDTH-1:0] cmd_period,
  input  logic                 cmd_abort,
  output logic                 enc_a,
  output logic                 enc_b,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     position
);

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [WIDTH-1:0] pos_q, pos_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dir_q, dir_d;
  logic             done_q, done_d;

  logic accept;
  logic run_en;
  logic tick;
  logic last_step;

  assign accept    = (state_q == IDLE) && cmd_valid;
  // Abort suppresses the tick so a coinciding edge is never emitted.
  assign run_en    = (state_q == RUN) && !cmd_abort;
  assign last_step = (rem_q == WIDTH'(1));

  quad_step_timer #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_timer (
    .clk     (clk),
    .rst     (reset),
    .load_i  (accept),
    .period_i(cmd_period),
    .en_i    (run_en),
    .tick_o  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept && (cmd_steps != '0)) state_d = RUN;
      RUN: begin
        if (cmd_abort)              state_d = IDLE;
        else if (tick && last_step) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q == RUN);
    enc_a     = phase_q[1];
    enc_b     = phase_q[0];
    done      = done_q;
    position  = pos_q;
  end

  always_comb begin
    phase_d = phase_q;
    pos_d   = pos_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          dir_d  = cmd_dir;
          rem_d  = cmd_steps;
          done_d = (cmd_steps == '0);
        end
      end
      RUN: begin
        if (cmd_abort) begin
          done_d = 1'b1;
        end else if (tick) begin
          if (dir_q == DIR_FWD) begin
            phase_d = phase_fwd(phase_q);
            pos_d   = pos_q + WIDTH'(1);
          end else begin
            phase_d = phase_rev(phase_q);
            pos_d   = pos_q - WIDTH'(1);
          end
          rem_d  = rem_q - WIDTH'(1);
          done_d = last_step;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q <= PH_00;
      pos_q   <= '0;
      rem_q   <= '0;
      dir_q   <= DIR_FWD;
      done_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      pos_q   <= pos_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_quad_encoder_gen.sv
// Self-checking bench for quad_encoder_gen: an edge-count model derived from
// accept cycle, period and step count, compared every cycle, plus literal checks.
module tb_quad_encoder_gen;
  localparam int W  = 8;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_dir = 1'b0;
  logic [W-1:0]  cmd_steps = '0;
  logic [DW-1:0] cmd_period = '0;
  logic          cmd_abort = 1'b0;
  logic          enc_a, enc_b, busy, done;
  logic [W-1:0]  position;

  quad_encoder_gen #(.WIDTH(W), .DIV_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_period(cmd_period),
    .cmd_abort(cmd_abort), .enc_a(enc_a), .enc_b(enc_b), .busy(busy),
    .done(done), .position(position)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Forward phase order; index advances by +1 per forward edge, -1 per reverse.
  logic [1:0] ph_tab [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  // Model of the current command: everything follows from accept edge, period
  // and step count (edges emitted by edge e = floor((e-k)/P), capped).
  bit m_active;
  int m_k, m_p, m_steps, m_dir, m_ka, m_base_idx, m_base_pos, m_prev_end;
  bit chk_en = 1'b0;

  function automatic int end_edge();
    if (m_steps == 0) return m_k;
    if (m_ka >= 0)    return m_ka;
    return m_k + m_steps * m_p;
  endfunction

  function automatic int edges_at(input int e);
    if (!m_active || e < m_k) return 0;
    if (e < end_edge())       return (e - m_k) / m_p;
    if (m_steps == 0)         return 0;
    if (m_ka >= 0)            return (m_ka - 1 - m_k) / m_p;
    return m_steps;
  endfunction

  function automatic int delta_at(input int e);
    int n;
    n = edges_at(e);
    return (m_dir != 0) ? n : -n;
  endfunction

  task automatic model_init();
    m_active = 1'b0; m_k = 0; m_p = 1; m_steps = 0; m_dir = 1; m_ka = -1;
    m_base_idx = 0; m_base_pos = 0; m_prev_end = -100;
  endtask

  // Bench-side decoder, as a channel would see the pair.
  int dec_count = 0;
  logic [1:0] prev_ab = 2'b00;

  function automatic int ab_idx(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (ph_tab[i] == ab) return i;
    return 0;
  endfunction

  always @(negedge clk) begin
    if (chk_en && !reset) begin
      int e, d, idx, pos, end_e, step;
      bit exp_busy, exp_done;
      logic [1:0] ab;
      e     = cyc;
      d     = delta_at(e);
      idx   = (m_base_idx + d) & 3;
      pos   = (m_base_pos + d) & ((1 << W) - 1);
      end_e = end_edge();
      exp_busy = m_active && e >= m_k && e < end_e && m_steps != 0;
      exp_done = (m_active && e >= m_k && e == end_e) || (e == m_prev_end);
      ab = {enc_a, enc_b};
      chk("enc_ab", int'(ab), int'(ph_tab[idx]));
      chk("position", int'(position), pos);
      chk("busy", int'(busy), int'(exp_busy));
      chk("cmd_ready", int'(cmd_ready), int'(!exp_busy));
      chk("done", int'(done), int'(exp_done));
      chk("single_edge", int'((ab ^ prev_ab) != 2'b11), 1);
      step = (ab_idx(ab) - ab_idx(prev_ab)) & 3;
      if (step == 1) dec_count++;
      else if (step == 3) dec_count--;
      prev_ab = ab;
    end
  end

  task automatic wait_until(input int e);
    int guard;
    guard = 0;
    while (cyc < e && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc < e) chk("wait_timeout", cyc, e);
  endtask

  // Called at a negedge; the command is accepted on the following posedge.
  task automatic send(input bit dir, input int steps, input int period, input bit hold);
    int guard;
    int fd;
    guard = 0;
    while (!cmd_ready && guard < 3000) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) chk("ready_timeout", 0, 1);
    if (m_active) begin
      fd = delta_at(1 << 30);
      m_base_idx = (m_base_idx + fd) & 3;
      m_base_pos = (m_base_pos + fd) & ((1 << W) - 1);
      m_prev_end = end_edge();
    end
    m_active = 1'b1;
    m_k = cyc + 1;
    m_p = (period == 0) ? 1 : period;
    m_steps = steps;
    m_dir = dir ? 1 : 0;
    m_ka = -1;
    cmd_dir = dir;
    cmd_steps = W'(steps);
    cmd_period = DW'(period);
    cmd_valid = 1'b1;
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic abort_at(input int ka);
    wait_until(ka - 1);
    m_ka = ka;
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 1'b0;
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_abort = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_init();
    prev_ab = 2'b00;
    dec_count = 0;
    chk_en = 1'b1;
  endtask

  int k;

  initial begin
    model_init();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_ab", int'({enc_a, enc_b}), 0);
    chk("rst_ready", int'(cmd_ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pos", int'(position), 0);
    @(negedge clk);

    // Forward, 4 steps, period 3
    send(1'b1, 4, 3, 1'b0);
    k = m_k;
    wait_until(k + 2);  chk("f_ab_k2", int'({enc_a, enc_b}), 0);
    wait_until(k + 3);  chk("f_ab_k3", int'({enc_a, enc_b}), 2);
    wait_until(k + 6);  chk("f_ab_k6", int'({enc_a, enc_b}), 3);
    wait_until(k + 9);  chk("f_ab_k9", int'({enc_a, enc_b}), 1);
    wait_until(k + 12);
    chk("f_ab_k12", int'({enc_a, enc_b}), 0);
    chk("f_done_k12", int'(done), 1);
    chk("f_ready_k12", int'(cmd_ready), 1);
    chk("f_pos_k12", int'(position), 4);
    wait_until(k + 13); chk("f_done_k13", int'(done), 0);

    // Reverse, 2 steps, period 0 from reset
    do_reset();
    send(1'b0, 2, 0, 1'b0);
    k = m_k;
    wait_until(k + 1);  chk("r_ab_k1", int'({enc_a, enc_b}), 1);
    wait_until(k + 2);
    chk("r_ab_k2", int'({enc_a, enc_b}), 3);
    chk("r_pos_k2", int'(position), 254);
    chk("r_done_k2", int'(done), 1);

    // Zero-step command, then back-to-back command
    wait_until(k + 4);
    send(1'b1, 0, 5, 1'b0);
    k = m_k;
    chk("z_done", int'(done), 1);
    chk("z_busy", int'(busy), 0);
    chk("z_pos", int'(position), 254);
    send(1'b1, 1, 1, 1'b0);
    chk("z_next_accept", m_k, k + 1);
    wait_until(m_k + 1);
    chk("z_next_pos", int'(position), 255);

    // Abort on the 3rd tick, valid held during RUN
    do_reset();
    send(1'b1, 10, 2, 1'b1);
    k = m_k;
    abort_at(k + 6);
    chk("a_ab", int'({enc_a, enc_b}), 3);
    chk("a_pos", int'(position), 2);
    chk("a_done", int'(done), 1);
    chk("a_busy", int'(busy), 0);
    send(1'b0, 2, 1, 1'b0);
    chk("a_held_accept", m_k, k + 7);
    wait_until(m_k + 2);
    chk("a_rev_ab", int'({enc_a, enc_b}), 0);
    chk("a_rev_pos", int'(position), 0);

    // Loopback: forward 8 then reverse 8
    do_reset();
    send(1'b1, 8, 4, 1'b0);
    wait_until(m_k + 8 * 4 + 1);
    chk("lb_dec_fwd", dec_count, 8);
    chk("lb_pos_fwd", int'(position), 8);
    send(1'b0, 8, 4, 1'b0);
    wait_until(m_k + 8 * 4 + 1);
    chk("lb_dec_rev", dec_count, 0);
    chk("lb_pos_rev", int'(position), 0);

    // Asynchronous reset in the middle of a move
    do_reset();
    send(1'b1, 5, 3, 1'b0);
    k = m_k;
    wait_until(k + 4);
    chk("mr_ab_before", int'({enc_a, enc_b}), 2);
    #2;
    chk_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("mr_ab", int'({enc_a, enc_b}), 0);
    chk("mr_pos", int'(position), 0);
    chk("mr_busy", int'(busy), 0);
    chk("mr_ready", int'(cmd_ready), 1);
    chk("mr_done", int'(done), 0);
    @(negedge clk);
    reset = 1'b0;
    model_init();
    prev_ab = 2'b00;
    chk_en = 1'b1;
    repeat (6) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_encoder_gen.md
Name: quad_encoder_gen

Overview:
- Quadrature encoder emulator: the transmit-side counterpart of the encoder decoder in each rgb_mixer channel.
- Accepts move commands over a valid/ready handshake: direction, step count and step period.
- Emits a Gray-coded A/B pair at the commanded rate, and tracks the resulting position.
- Used as a stimulus source for channel/mixer benches and as an on-chip self-test driver for the enc*_a/enc*_b inputs.

Parameters:
- WIDTH, 8: width of the step count and of the position counter.
- DIV_WIDTH, 16: width of the step period (clock cycles per quadrature edge).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_dir  in  1  1 = forward (A leads B), 0 = reverse (B leads A)
- cmd_steps  in  WIDTH  number of quadrature edges (state changes) to emit
- cmd_period  in  DIV_WIDTH  clock cycles between edges; 0 is treated as 1
- cmd_abort  in  1  stop the current move immediately
- enc_a  out  1  quadrature phase A (registered)
- enc_b  out  1  quadrature phase B (registered)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse when a command completes or is aborted
- position  out  WIDTH  count of edges emitted: +1 per forward edge, -1 per reverse edge, wraps mod 2^WIDTH

Behaviour:
- One clock. Reset is asynchronous and active-high.
- Reset values: enc_a=0, enc_b=0, cmd_ready=1, busy=0, done=0, position=0, state=IDLE, internal timer=0, remaining=0.
- Phase encoding {A,B}:
  - Forward sequence: 00→10→11→01→00.
  - Reverse sequence: 00→01→11→10→00.
  - Phase persists across commands; it returns to 00 only on reset.
- States: IDLE, RUN.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid & cmd_ready at clock edge k, latch dir, steps, and period P (P=max(cmd_period,1)). Load timer=P-1.
  - If steps==0: stay in IDLE, done=1 in the cycle after edge k, no edge, position unchanged.
  - Otherwise: go to RUN with remaining=steps.
  - cmd_abort is ignored in IDLE.
- RUN:
  - cmd_ready=0; cmd_valid is ignored.
  - Each cycle with timer!=0: timer decrements.
  - Each cycle with timer==0:
    - Advance phase one step in the latched direction.
    - Update position by ±1.
    - Reload timer=P-1 and decrement remaining.
    - If remaining was 1: go to IDLE and register done=1 on the same edge.
  - First edge appears at clock edge k+P, and subsequent edges every P cycles. The last edge, done=1 and cmd_ready=1 all become visible in the same cycle.
- Abort:
  - cmd_abort=1 in RUN forces IDLE and done=1 on the next edge.
  - Phase and position are held.
  - If abort coincides with timer==0, abort wins and no edge is emitted.
- Single-edge guarantee: enc_a and enc_b never change in the same cycle, so each edge is a single-bit change.
- Wrap-around: position wraps silently (0 minus 1 gives 2^WIDTH-1). The timer never wraps because it reloads at 0.
- Reset mid-operation: all outputs return to their reset values asynchronously, with no clock required. The in-flight command is discarded and no done pulse is produced.
- done is asserted only for the single cycle after completion or abort.

Decomposition:
- Package quad_pkg:
  - State enum {IDLE, RUN}.
  - 2-bit phase constants PH_00, PH_10, PH_11, PH_01.
  - Forward/reverse next-phase functions.
  - DIR_FWD/DIR_REV constants.
- Sub-module quad_step_timer (DIV_WIDTH):
  - Loadable down-counter with load, period, and tick out (asserted when the count is 0 and the counter is enabled).
  - Reloads itself on tick.
  - The top FSM owns phase, position and remaining.

Test Plan:
- Reset released → enc_a=0, enc_b=0, cmd_ready=1, busy=0, done=0, position=0. Assert reset asynchronously mid-RUN → outputs drop to reset values before the next clk edge.
- Forward, steps=4, period=3, accepted at edge 0 → {A,B}=10 @3, 11 @6, 01 @9, 00 @12. done high for exactly cycle 12→13, cmd_ready=1 from 12, position=4. No cycle has A and B changing together.
- From reset, reverse, steps=2, period=0 (treated as 1) → {A,B}=01 @1, 11 @2. position=254 (WIDTH=8), done after edge 2.
- steps=0 command → no A/B change, busy stays 0, done pulses one cycle after accept, position unchanged. A second command offered on the next cycle is accepted.
- Forward, steps=10, period=2; cmd_abort asserted on the cycle of the 3rd tick → exactly 2 edges emitted, phase held at 11, position=2, one done pulse. cmd_valid held high during RUN is not accepted until cmd_ready=1.
- Loopback into a channel (debouncers + decoder) with period ≥ debounce latency: forward 8 edges then reverse 8 edges → channel count returns to its start value, and the generator's position returns to 0.
